sha_hex_tx_ctrl: RTL

Sequences the byte-serial UART transmitter to print a SHA-256 digest as ASCII hex text. It latches a 256-bit digest on a start pulse and emits 64 lowercase hex characters, MSB nibble first, followed by optional CR LF. It sits between the SHA-256 core's result register and the UART transmitter. It owns the transmitter's data-valid/byte inputs exclusively.

---
 rtl/sha_uart_pkg.sv | 20 ++
 rtl/nibble_to_ascii.sv | 20 ++
 rtl/sha_hex_tx_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sha_uart_pkg.sv
// Shared definitions for the SHA-256 digest hex printer: controller state
// encoding and the ASCII constants used to build output characters.
package sha_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_WAIT_CLR  = 3'd4,
    ST_DONE      = 3'd5
  } tx_state_e;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LA   = 8'h61;
  localparam logic [7:0] ASCII_UA   = 8'h41;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational conversion of one 4-bit nibble to its ASCII hex character.
module nibble_to_ascii
  import sha_uart_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       uppercase,
  output logic [7:0] ascii
);

  // Digits map onto '0'..'9'; 10..15 map onto 'a'..'f' or 'A'..'F'.
  always_comb begin
    ascii = ASCII_ZERO;
    if (nibble < 4'd10) begin
      ascii = ASCII_ZERO + {4'h0, nibble};
    end else begin
      ascii = (uppercase ? ASCII_UA : ASCII_LA) + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/sha_hex_tx_ctrl.sv
// Prints a latched digest as ASCII hex through a byte-serial UART
// transmitter, most significant nibble first, optionally followed by CR LF.
//
// Transmitter handshake: o_Tx_DV is a one-cycle pulse with o_Tx_Byte valid in
// that cycle; a new byte is offered only while the transmitter reports neither
// i_Tx_Active nor i_Tx_Done, and each byte is closed by seeing i_Tx_Done rise
// and then fall again, so a done level held for several cycles counts once.
module sha_hex_tx_ctrl
  import sha_uart_pkg::*;
#(
  parameter int DIGEST_BITS = 256,
  parameter bit APPEND_CRLF = 1'b1,
  parameter bit UPPERCASE   = 1'b0
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_n,
  input  logic                   i_Start,
  input  logic [DIGEST_BITS-1:0] i_Digest,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done,
  output logic [2:0]             o_Dbg_State
);

  localparam int NCHAR = DIGEST_BITS / 4;
  localparam int TOTAL = NCHAR + (APPEND_CRLF ? 2 : 0);
  localparam int CW    = $clog2(NCHAR + 3);

  localparam logic [CW-1:0] NCHAR_C = CW'(NCHAR);
  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);

  tx_state_e              state_q;
  logic [CW-1:0]          idx_q;
  logic [DIGEST_BITS-1:0] shift_q;
  logic [7:0]             hex_char;
  logic [7:0]             next_byte;

  assign o_Dbg_State = state_q;

  nibble_to_ascii u_nibble_to_ascii (
    .nibble    (shift_q[DIGEST_BITS-1 -: 4]),
    .uppercase (UPPERCASE),
    .ascii     (hex_char)
  );

  // Character for the current index: hex digit, then the CR / LF trailer.
  always_comb begin
    next_byte = hex_char;
    if (idx_q >= NCHAR_C) begin
      next_byte = (idx_q == NCHAR_C) ? ASCII_CR : ASCII_LF;
    end
  end

  // Main sequencer; all outputs are registered and cleared by reset.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      shift_q   <= '0;
      o_Busy    <= 1'b0;
      o_Done    <= 1'b0;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
    end else begin
      o_Tx_DV <= 1'b0;
      o_Done  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_Start) begin
            shift_q <= i_Digest;
            idx_q   <= '0;
            o_Busy  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          o_Tx_Byte <= next_byte;
          state_q   <= ST_SEND;
        end
        ST_SEND: begin
          if (!i_Tx_Active && !i_Tx_Done) begin
            o_Tx_DV <= 1'b1;
            state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (i_Tx_Done) begin
            if (idx_q < NCHAR_C) begin
              shift_q <= shift_q << 4;
            end
            idx_q   <= idx_q + CW'(1);
            state_q <= ST_WAIT_CLR;
          end
        end
        ST_WAIT_CLR: begin
          if (!i_Tx_Done) begin
            if (idx_q == TOTAL_C) begin
              o_Done  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          o_Busy  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          o_Busy  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
